// File: rtl/pipe_pkg.sv
// Shared types and helpers for the pipeline registers between core stages.
// The default payload layout matches a 32-bit instruction and 32-bit address core.
package pipe_pkg;

    localparam int unsigned INSTR_W_DEF = 32;
    localparam int unsigned ADDR_W_DEF  = 32;

    // Instruction value shown to a stage that holds no real instruction.
    localparam logic [31:0] BUBBLE_INSTR = 32'h0000_0000;

    typedef struct packed {
        logic [INSTR_W_DEF-1:0] instr;
        logic [ADDR_W_DEF-1:0]  pc;
        logic [ADDR_W_DEF-1:0]  pcplus4;
    } fd_payload_t;

    // Bits needed to hold an occupancy of 0..depth.
    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

    // Bits needed to index 0..depth-1; at least one so a single-entry FIFO still has a pointer.
    function automatic int unsigned ptr_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/skid_fifo.sv
// Small circular FIFO absorbing fetches while the consumer is stalled.
// Pointers wrap modulo DEPTH, so DEPTH does not have to be a power of two.
module skid_fifo
    import pipe_pkg::*;
#(
    parameter int unsigned DEPTH     = 2,
    parameter type         payload_t = fd_payload_t
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          clear_i,
    input  logic                          push_i,
    input  logic                          pop_i,
    input  payload_t                      data_i,
    output logic                          full_o,
    output logic                          empty_o,
    output logic [cnt_width(DEPTH)-1:0]   count_o,
    output payload_t                      head_o
);

    localparam int unsigned PtrW = ptr_width(DEPTH);
    localparam int unsigned CntW = cnt_width(DEPTH);
    localparam logic [PtrW-1:0] LastPtr  = PtrW'(DEPTH - 1);
    localparam logic [CntW-1:0] DepthCnt = CntW'(DEPTH);

    payload_t mem_q [DEPTH];

    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            do_push, do_pop;

    function automatic logic [PtrW-1:0] inc_ptr(input logic [PtrW-1:0] ptr);
        return (ptr == LastPtr) ? '0 : ptr + 1'b1;
    endfunction

    assign full_o  = (cnt_q == DepthCnt);
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;
    assign head_o  = mem_q[rd_ptr_q];

    assign do_pop  = pop_i & ~empty_o;
    // A push into a full FIFO is only safe when the head leaves on the same edge.
    assign do_push = push_i & (~full_o | do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (do_push) begin
                wr_ptr_d = inc_ptr(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_d = inc_ptr(rd_ptr_q);
            end
            unique case ({do_push, do_pop})
                2'b10:   cnt_d = cnt_q + 1'b1;
                2'b01:   cnt_d = cnt_q - 1'b1;
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(negedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage needs no reset: an entry is only visible once the count covers it.
    always_ff @(negedge clk_i) begin
        if (do_push && !clear_i) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/fd_skid_pipe_reg.sv
// Fetch-to-decode pipeline register with a skid FIFO, flush-to-bubble and valid tracking.
// Fetch sees ReadyF instead of a hard stall; decode sees instructions strictly in fetch order.
module fd_skid_pipe_reg
    import pipe_pkg::*;
#(
    parameter int unsigned         INSTR_W = 32,
    parameter int unsigned         ADDR_W  = 32,
    parameter int unsigned         DEPTH   = 2,
    parameter logic [INSTR_W-1:0]  BUBBLE  = INSTR_W'(BUBBLE_INSTR)
) (
    input  logic                         CLK,
    input  logic                         CLR_N,
    input  logic                         StallD,
    input  logic                         FlushD,
    input  logic                         ValidF,
    input  logic [INSTR_W-1:0]           InstrF,
    input  logic [ADDR_W-1:0]            PCF,
    input  logic [ADDR_W-1:0]            PCPlus4F,
    output logic                         ReadyF,
    output logic [INSTR_W-1:0]           InstrD,
    output logic [ADDR_W-1:0]            PCD,
    output logic [ADDR_W-1:0]            PCPlus4D,
    output logic                         ValidD,
    output logic [cnt_width(DEPTH)-1:0]  SkidCnt
);

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [ADDR_W-1:0]  pc;
        logic [ADDR_W-1:0]  pcplus4;
    } payload_t;

    localparam payload_t BubblePayload = '{instr: BUBBLE, pc: '0, pcplus4: '0};

    payload_t out_q, out_d;
    logic     valid_q, valid_d;
    logic     rdy_en_q;

    payload_t                    fetch_pl;
    payload_t                    fifo_head;
    logic                        fifo_push, fifo_pop, fifo_clear;
    logic                        fifo_full, fifo_empty;
    logic [cnt_width(DEPTH)-1:0] fifo_cnt;
    logic                        accept;

    assign fetch_pl = '{instr: InstrF, pc: PCF, pcplus4: PCPlus4F};

    // Ready depends only on registered state, keeping StallD/FlushD off the fetch timing path.
    assign ReadyF = rdy_en_q & ~fifo_full;
    assign accept = ValidF & ReadyF & ~FlushD;

    skid_fifo #(
        .DEPTH     (DEPTH),
        .payload_t (payload_t)
    ) u_skid_fifo (
        .clk_i   (CLK),
        .rst_ni  (CLR_N),
        .clear_i (fifo_clear),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .data_i  (fetch_pl),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_cnt),
        .head_o  (fifo_head)
    );

    always_comb begin
        out_d      = out_q;
        valid_d    = valid_q;
        fifo_push  = 1'b0;
        fifo_pop   = 1'b0;
        fifo_clear = 1'b0;
        if (FlushD) begin
            fifo_clear = 1'b1;
            out_d      = BubblePayload;
            valid_d    = 1'b0;
        end else if (!StallD) begin
            if (!fifo_empty) begin
                // Older skid entries always drain ahead of the fetch currently offered.
                out_d     = fifo_head;
                valid_d   = 1'b1;
                fifo_pop  = 1'b1;
                fifo_push = accept;
            end else if (accept) begin
                out_d   = fetch_pl;
                valid_d = 1'b1;
            end else begin
                out_d   = BubblePayload;
                valid_d = 1'b0;
            end
        end else begin
            fifo_push = accept;
        end
    end

    always_ff @(negedge CLK or negedge CLR_N) begin
        if (!CLR_N) begin
            out_q    <= BubblePayload;
            valid_q  <= 1'b0;
            rdy_en_q <= 1'b0;
        end else begin
            out_q    <= out_d;
            valid_q  <= valid_d;
            rdy_en_q <= 1'b1;
        end
    end

    assign InstrD   = out_q.instr;
    assign PCD      = out_q.pc;
    assign PCPlus4D = out_q.pcplus4;
    assign ValidD   = valid_q;
    assign SkidCnt  = fifo_cnt;

endmodule

// File: doc/fd_skid_pipe_reg.md
Name: fd_skid_pipe_reg

Overview:
- Parametrised Fetch→Decode pipeline register. Carries instruction, PC, PCPlus4 and a valid bit.
- Adds a small skid FIFO so Fetch can complete in-flight fetches while Decode is stalled. Fetch sees a ready signal instead of a hard stall.
- Adds a synchronous flush that inserts a bubble, and per-stage valid tracking.
- Sits between the fetch stage and the decode stage of the pipelined core.

Parameters:
- INSTR_W, 32, instruction width.
- ADDR_W, 32, PC / PCPlus4 width.
- DEPTH, 2, skid FIFO entries; legal range 1..8.
- BUBBLE, 32'h0000_0000, instruction value driven on InstrD when ValidD=0.

Ports:
- CLK  input  1  pipeline clock.
- CLR_N  input  1  asynchronous active-low reset.
- StallD  input  1  decode hold request; 1 = output stage holds.
- FlushD  input  1  synchronous flush; 1 = discard all held/incoming fetches.
- ValidF  input  1  fetch presents a valid instruction.
- InstrF  input  INSTR_W  fetched instruction.
- PCF  input  ADDR_W  fetch PC.
- PCPlus4F  input  ADDR_W  fetch PC+4.
- ReadyF  output  1  fetch transfer accepted this edge when ValidF & ReadyF.
- InstrD  output  INSTR_W  decode instruction.
- PCD  output  ADDR_W  decode PC.
- PCPlus4D  output  ADDR_W  decode PC+4.
- ValidD  output  1  decode stage holds a real instruction.
- SkidCnt  output  $clog2(DEPTH+1)  current FIFO occupancy (perf/debug).

Behaviour:
- All state updates on the falling edge of CLK, matching the rest of the pipeline registers.
- Reset (CLR_N=0, asynchronous):
  - InstrD=BUBBLE, PCD=0, PCPlus4D=0, ValidD=0.
  - FIFO empty, SkidCnt=0.
  - ReadyF=0 while CLR_N low; ReadyF=1 from the first falling edge after release.
- ReadyF = (SkidCnt < DEPTH), from registered count only. No combinational path from StallD or FlushD to ReadyF.
- accept = ValidF & ReadyF & !FlushD.
- Priority per edge:
  1. FlushD=1 (overrides StallD):
     - output ← bubble (InstrD=BUBBLE, PCD=PCPlus4D=0, ValidD=0).
     - FIFO pointers and count cleared.
     - fetch data on this edge dropped.
  2. StallD=0, FIFO non-empty:
     - output ← FIFO head, ValidD=1; pop.
     - If accept, push F in the same edge; count unchanged.
  3. StallD=0, FIFO empty:
     - accept → output ← F directly (bypass, 1-edge latency), ValidD=1.
     - else output ← bubble, ValidD=0.
  4. StallD=1:
     - output holds all fields including ValidD.
     - accept → push F into FIFO, count+1.
- Ordering: strict FIFO. Instructions reach decode in fetch order; none duplicated or lost except by FlushD.
- FIFO boundaries:
  - Read/write pointers wrap modulo DEPTH; DEPTH need not be a power of two.
  - Full (count=DEPTH) → ReadyF=0; fetch must hold ValidF/data stable.
  - ValidF while !ReadyF is legal; nothing is captured.
  - Stalled with empty FIFO and a valid output: capacity is DEPTH more instructions.
  - Stall released while full: that edge pops only; ReadyF rises the next edge.
- Reset mid-stall or mid-fill: all state cleared immediately. No partial entries survive.
- ValidD=0 entries are never stored in the FIFO.

Decomposition:
- Package pipe_pkg:
  - typedef fd_payload_t (instr, pc, pcplus4).
  - BUBBLE_INSTR constant, reused by the other pipe registers.
  - helper function for the count width.
- One sub-module: skid_fifo.
  - Parametrised by DEPTH and payload type.
  - Ports: push, pop, clear, full, empty, count, head.
  - Same clock edge and asynchronous active-low reset as the parent.
- The top level holds the output register and the priority logic.

Test Plan:
- Reset/stream: release CLR_N, StallD=0, ValidF every edge with PCF=0,4,8 → ReadyF=1; PCD=0,4,8 one edge later each; ValidD=1; SkidCnt stays 0.
- Stall fill: stream PCF=0x100.., assert StallD for 4 edges with DEPTH=2 → output holds 0x100; SkidCnt 1,2; ReadyF=0 after 2 pushes. Release StallD → PCD=0x104, 0x108, 0x10C in order; no PC skipped or duplicated.
- Flush priority: FIFO holding 2 entries, StallD=1 and FlushD=1 on the same edge → ValidD=0, InstrD=BUBBLE, SkidCnt=0, ReadyF=1 next edge; the entry offered on the flush edge never appears.
- Bubble: ValidF=0 with StallD=0 → ValidD=0, InstrD=BUBBLE. ValidF=0 while stalled → SkidCnt unchanged.
- Simultaneous pop/push: SkidCnt=1, StallD=0, ValidF=1 → SkidCnt stays 1; decode gets the older instruction first.
- Async reset mid-fill: drop CLR_N between edges with SkidCnt=2 → outputs zero immediately, no edge needed; ReadyF=0 until release. Repeat with DEPTH=1 and DEPTH=3 to check wrap-around.
